// File: rtl/pmd901_pkg.sv
// Shared definitions for the PMD901 speed-ramp command stage.
// Optional build macro: PMD901_RAMP_FAULT_STOP_EN adds the FAULT state.
package pmd901_pkg;

  // Default speed word width (two's complement)
  localparam int SPEED_W = 16;

  // Ramp controller states; FAULT is only built with the fault-stop feature
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1
`ifdef PMD901_RAMP_FAULT_STOP_EN
    ,
    ST_FAULT = 2'd2
`endif
  } state_e;

  // Clamp a signed value into [-lim, +lim]; done at 32 bits so any SPEED_W up to 32 fits
  function automatic logic signed [31:0] clamp_speed(input logic signed [31:0] v,
                                                     input logic signed [31:0] lim);
    if (v > lim) begin
      return lim;
    end else if (v < -lim) begin
      return -lim;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/pmd901_tick_gen.sv
// Free-running tick generator: counts 0..TICK_CYCLES-1 and flags the wrap cycle.
module pmd901_tick_gen
#(
  parameter int TICK_CYCLES = 100000
)
(
  input  logic clk,
  input  logic rst,
  output logic tick
);
  import pmd901_pkg::*;

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: wrap to zero on the tick cycle, otherwise increment
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  // Counter register; only reset restarts the phase
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pmd901_speed_ramp.sv
// PMD901 speed-ramp command stage: accepts a signed setpoint, slews the applied
// speed toward it by a fixed step per tick and emits each applied value as a
// one-cycle write (wdata/we) for spi_top.
// Optional build macro: PMD901_RAMP_FAULT_STOP_EN -- when defined, the fault pin
// forces an immediate zero-speed write and holds the block in FAULT until released.
module pmd901_speed_ramp
#(
  parameter int                              SPEED_W     = pmd901_pkg::SPEED_W,
  parameter int                              TICK_CYCLES = 100000,
  parameter logic signed [SPEED_W-1:0]       SPEED_MAX   = 16'sd30000
)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [SPEED_W-1:0] tgt_speed,
  input  logic                      tgt_valid,
  output logic                      tgt_ready,
  input  logic        [SPEED_W-1:0] step,
  input  logic                      fault,
  output logic signed [SPEED_W-1:0] wdata,
  output logic                      we,
  output logic signed [SPEED_W-1:0] cur_speed,
  output logic                      at_target,
  output logic                      busy
);
  import pmd901_pkg::*;

  // One extra bit so target - cur_speed never wraps
  localparam int DW = SPEED_W + 1;

  logic tick;

  state_e                    state_q,  state_d;
  logic signed [SPEED_W-1:0] cur_q,    cur_d;
  logic signed [SPEED_W-1:0] target_q, target_d;
  logic signed [SPEED_W-1:0] wdata_q,  wdata_d;
  logic                      we_q,     we_d;

  logic                      accept;
  logic signed [SPEED_W-1:0] tgt_clamped;
  logic        [SPEED_W-1:0] step_mag;
  logic signed [DW-1:0]      step_eff;
  logic signed [DW-1:0]      diff;
  logic signed [DW-1:0]      diff_abs;
  logic signed [DW-1:0]      ramp_sum;
  logic signed [SPEED_W-1:0] next_cur;

  pmd901_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

`ifdef PMD901_RAMP_FAULT_STOP_EN
  assign tgt_ready = (state_q != ST_FAULT);
`else
  // The fault pin is kept on the port list but has no effect in this build
  logic unused_fault;
  assign unused_fault = fault;
  assign tgt_ready    = 1'b1;
`endif

  assign accept    = tgt_valid && tgt_ready;
  assign busy      = (state_q == ST_RAMP);
  assign at_target = (state_q == ST_IDLE);
  assign cur_speed = cur_q;
  assign wdata     = wdata_q;
  assign we        = we_q;

  // Setpoint clamp and one ramp step toward the currently latched target
  always_comb begin
    tgt_clamped = SPEED_W'(clamp_speed(32'(tgt_speed), 32'(SPEED_MAX)));
    step_mag    = (step == '0) ? SPEED_W'(1) : step;
    step_eff    = $signed({1'b0, step_mag});
    diff        = DW'(target_q) - DW'(cur_q);
    diff_abs    = diff[DW-1] ? -diff : diff;
    ramp_sum    = diff[DW-1] ? (DW'(cur_q) - step_eff) : (DW'(cur_q) + step_eff);
    next_cur    = (diff_abs <= step_eff) ? target_q : $signed(ramp_sum[SPEED_W-1:0]);
  end

  // Next-state logic: target capture, ramp updates on tick, optional fault stop
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    target_d = target_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;

    // A setpoint taken on a tick cycle only affects the next tick
    if (accept) begin
      target_d = tgt_clamped;
    end

    case (state_q)
      ST_IDLE: begin
        if (target_q != cur_q) begin
          state_d = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (tick) begin
          cur_d   = next_cur;
          wdata_d = next_cur;
          we_d    = 1'b1;
          if (next_cur == target_q) begin
            state_d = ST_IDLE;
          end
        end
      end
`ifdef PMD901_RAMP_FAULT_STOP_EN
      ST_FAULT: begin
        if (!fault) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef PMD901_RAMP_FAULT_STOP_EN
    // Entering FAULT writes zero speed once; staying in FAULT writes nothing
    if (fault && (state_q != ST_FAULT)) begin
      cur_d    = '0;
      target_d = '0;
      wdata_d  = '0;
      we_d     = 1'b1;
      state_d  = ST_FAULT;
    end
`endif
  end

  // State and output registers; reset aborts any ramp without a write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      target_q <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      target_q <= target_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
    end
  end

endmodule
